// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the HD44780 command scheduler.
//   state_e        : scheduler FSM state (also exported for debug)
//   LCD_*          : common HD44780 instruction bytes
//   *_DEF          : default bus / execution timing in 50 MHz clock cycles
//   is_long_cmd()  : true for instructions needing the 1.64 ms execution wait
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN,
    S_HOLD,
    S_EXEC,
    S_POLL_SETUP,
    S_POLL_EN,
    S_POLL_HOLD
  } state_e;

  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_RETURN   = 8'h02;
  localparam logic [7:0] LCD_MODE_SET = 8'h06;
  localparam logic [7:0] LCD_DISPLAY  = 8'h0C;
  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DDRAM    = 8'h80;

  localparam int T_SETUP_DEF      = 4;
  localparam int T_EN_HIGH_DEF    = 12;
  localparam int T_HOLD_DEF       = 4;
  localparam int EXEC_SHORT_DEF   = 2000;
  localparam int EXEC_LONG_DEF    = 82000;
  localparam int MAX_HI_BURST_DEF = 4;

  // Clear (0x01) and return-home (0x02, 0x03: bit 0 is don't-care) are the
  // only slow instructions; data writes are never slow.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CLEAR) || (data == LCD_RETURN) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_cmd_scheduler_if.sv
// ---------------------------------------------------------------------------
// lcd_cmd_scheduler_if
// Request bundle for the two LCD requesters.
//   port 0 (init/config, high priority): i_req0_valid/rs/data, o_req0_ready
//   port 1 (text writer)               : i_req1_valid/rs/data, o_req1_ready
// Handshake: a word {rs, data} transfers in a cycle where validN && readyN.
// readyN is combinational and may depend on validN; the requester keeps
// valid, rs and data stable until it sees ready. Dropping valid before ready
// is allowed and simply withdraws the request. At most one ready is high in
// any cycle.
// modports: master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface lcd_cmd_scheduler_if;
  logic       i_req0_valid;
  logic       i_req0_rs;
  logic [7:0] i_req0_data;
  logic       o_req0_ready;
  logic       i_req1_valid;
  logic       i_req1_rs;
  logic [7:0] i_req1_data;
  logic       o_req1_ready;

  modport master (
    output i_req0_valid, i_req0_rs, i_req0_data,
    output i_req1_valid, i_req1_rs, i_req1_data,
    input  o_req0_ready, o_req1_ready
  );

  modport slave (
    input  i_req0_valid, i_req0_rs, i_req0_data,
    input  i_req1_valid, i_req1_rs, i_req1_data,
    output o_req0_ready, o_req1_ready
  );
endinterface

// File: rtl/lcd_req_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_req_arbiter
// Fixed priority for port 0 with a burst limit so port 1 cannot starve.
// Ports:
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_idle                 : scheduler can take a word this cycle
//   i_req0_valid/1_valid   : request valids
//   o_req0_ready/1_ready   : combinational accept strobes (one-hot or zero)
// ---------------------------------------------------------------------------
module lcd_req_arbiter #(
  parameter int MAX_HI_BURST = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_idle,
  input  logic i_req0_valid,
  input  logic i_req1_valid,
  output logic o_req0_ready,
  output logic o_req1_ready
);

  localparam int BW = $clog2(MAX_HI_BURST + 1);

  logic [BW-1:0] burst_q, burst_d;
  logic          burst_full;
  logic          grant0, grant1;

  assign burst_full = (burst_q == BW'(MAX_HI_BURST));

  // Readies are forced low while reset is asserted so nothing is accepted.
  assign grant0 = i_rst_n && i_idle && i_req0_valid && !(i_req1_valid && burst_full);
  assign grant1 = i_rst_n && i_idle && i_req1_valid && !grant0;

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  // The counter only measures port-0 wins while port 1 is actually waiting.
  always_comb begin
    burst_d = burst_q;
    if (!i_req1_valid || grant1) begin
      burst_d = '0;
    end else if (grant0 && !burst_full) begin
      burst_d = burst_q + BW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_cmd_scheduler
// Shares an HD44780 16x2 LCD bus between two requesters and generates the
// RS/RW/EN/DATA write timing plus the post-command execution wait.
// Ports:
//   i_clk, i_rst_n   : 50 MHz clock, async active-low reset
//   req (slave)      : two-port request bundle (lcd_cmd_scheduler_if)
//   o_busy           : high whenever the FSM is not in S_IDLE
//   o_bf_timeout     : sticky busy-flag timeout (0 unless polling is built)
//   io_LCD_DATA      : LCD data bus
//   o_LCD_EN/RS/RW   : LCD strobes
//   o_LCD_ON/BLON    : LCD power and backlight, tied on
//   o_state_dbg      : current FSM state
// Build option: LCD_BF_POLL_EN replaces the fixed execution wait with
// busy-flag polling (RW=1 reads, bus tristated while reading).
// ---------------------------------------------------------------------------
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int T_SETUP      = T_SETUP_DEF,
  parameter int T_EN_HIGH    = T_EN_HIGH_DEF,
  parameter int T_HOLD       = T_HOLD_DEF,
  parameter int EXEC_SHORT   = EXEC_SHORT_DEF,
  parameter int EXEC_LONG    = EXEC_LONG_DEF,
  parameter int MAX_HI_BURST = MAX_HI_BURST_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lcd_cmd_scheduler_if.slave   req,
  output logic                 o_busy,
  output logic                 o_bf_timeout,
  inout  wire  [7:0]           io_LCD_DATA,
  output logic                 o_LCD_EN,
  output logic                 o_LCD_RS,
  output logic                 o_LCD_RW,
  output logic                 o_LCD_ON,
  output logic                 o_LCD_BLON,
  output state_e               o_state_dbg
);

  localparam int CW = $clog2(EXEC_LONG + 1);

  // Each phase lasting n cycles loads n-1 and leaves when the counter is 0.
  function automatic logic [CW-1:0] ld(input int n);
    return CW'(n - 1);
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    word_q, word_d;
  logic          idle;
  logic          accept;
  logic [8:0]    sel_word;
  logic          drive_word;
  logic [7:0]    bus_data;

  assign idle = (state_q == S_IDLE);

  lcd_req_arbiter #(
    .MAX_HI_BURST (MAX_HI_BURST)
  ) u_arb (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_idle       (idle),
    .i_req0_valid (req.i_req0_valid),
    .i_req1_valid (req.i_req1_valid),
    .o_req0_ready (req.o_req0_ready),
    .o_req1_ready (req.o_req1_ready)
  );

  assign accept   = (req.i_req0_valid && req.o_req0_ready) ||
                    (req.i_req1_valid && req.o_req1_ready);
  assign sel_word = req.o_req0_ready ? {req.i_req0_rs, req.i_req0_data}
                                     : {req.i_req1_rs, req.i_req1_data};

`ifdef LCD_BF_POLL_EN
  localparam int TW = $clog2(2 * EXEC_LONG + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          bf_q, bf_d;
  logic          bf_to_q, bf_to_d;
  logic          polling;

  assign polling = (state_q == S_POLL_SETUP) || (state_q == S_POLL_EN) ||
                   (state_q == S_POLL_HOLD);
`else
  logic long_q, long_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
`ifdef LCD_BF_POLL_EN
    tmo_d   = tmo_q;
    bf_d    = bf_q;
    bf_to_d = bf_to_q;
`else
    long_d  = long_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_d  = sel_word;
`ifndef LCD_BF_POLL_EN
          long_d  = is_long_cmd(sel_word[8], sel_word[7:0]);
`endif
          state_d = S_SETUP;
          cnt_d   = ld(T_SETUP);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EN;
          cnt_d   = ld(T_EN_HIGH);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EN: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = ld(T_HOLD);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef LCD_BF_POLL_EN
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_POLL_SETUP;
          cnt_d   = ld(T_SETUP);
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_POLL_SETUP, S_POLL_EN, S_POLL_HOLD: begin
        tmo_d = tmo_q + TW'(1);
        // Polling has already run 2*EXEC_LONG cycles: give up on the panel.
        if (tmo_q == TW'(2 * EXEC_LONG)) begin
          state_d = S_IDLE;
          bf_to_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (state_q == S_POLL_SETUP) begin
          state_d = S_POLL_EN;
          cnt_d   = ld(T_EN_HIGH);
        end else if (state_q == S_POLL_EN) begin
          // Last EN-high cycle: DB7 is the busy flag.
          state_d = S_POLL_HOLD;
          cnt_d   = ld(T_HOLD);
          bf_d    = io_LCD_DATA[7];
        end else if (bf_q) begin
          state_d = S_POLL_SETUP;
          cnt_d   = ld(T_SETUP);
        end else begin
          state_d = S_IDLE;
        end
      end
`else
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_EXEC;
          cnt_d   = long_q ? ld(EXEC_LONG) : ld(EXEC_SHORT);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // An accepted word is dropped by reset; the requester has to reissue it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef LCD_BF_POLL_EN
      tmo_q   <= '0;
      bf_q    <= 1'b0;
      bf_to_q <= 1'b0;
`else
      long_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef LCD_BF_POLL_EN
      tmo_q   <= tmo_d;
      bf_q    <= bf_d;
      bf_to_q <= bf_to_d;
`else
      long_q  <= long_d;
`endif
    end
  end

  // Pins decode straight from the state register so async reset clears EN
  // in the same cycle.
  assign drive_word = (state_q == S_SETUP) || (state_q == S_EN) || (state_q == S_HOLD);
  assign bus_data   = drive_word ? word_q[7:0] : 8'h00;
  assign o_LCD_RS   = drive_word && word_q[8];
  assign o_busy     = !idle;
  assign o_LCD_ON   = 1'b1;
  assign o_LCD_BLON = 1'b1;
  assign o_state_dbg = state_q;

`ifdef LCD_BF_POLL_EN
  assign o_LCD_EN     = (state_q == S_EN) || (state_q == S_POLL_EN);
  assign o_LCD_RW     = polling;
  assign io_LCD_DATA  = polling ? 8'hzz : bus_data;
  assign o_bf_timeout = bf_to_q;
`else
  assign o_LCD_EN     = (state_q == S_EN);
  assign o_LCD_RW     = 1'b0;
  assign io_LCD_DATA  = bus_data;
  assign o_bf_timeout = 1'b0;
`endif

endmodule
